// File: rtl/sharpen_pkg.sv
// Shared definitions for the sharpen frame scheduler.
//   CNT_W          : width of the pixel and line counters
//   DEF_*          : default frame geometry (640x480, 8-clock vsync lead,
//                    16-clock line blanking)
//   state_t, ST_*  : scheduler FSM encoding, also exported on dbg_state
package sharpen_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_ONE = 11'd1;

  localparam logic [CNT_W-1:0] DEF_IMG_HDISP = 11'd640;
  localparam logic [CNT_W-1:0] DEF_IMG_VDISP = 11'd480;
  localparam logic [7:0]       DEF_VS_LEAD   = 8'd8;
  localparam logic [7:0]       DEF_H_BLANK   = 8'd16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VLEAD  = 3'd1;
  localparam state_t ST_LINE   = 3'd2;
  localparam state_t ST_HBLANK = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;

endpackage

// File: rtl/sharpen_drain_mon.sv
// Returned-line monitor for the sharpen pipeline output.
// Counts falling edges of post_img_href and raises done once NUM_LINES
// lines have come back. The count is held at NUM_LINES until clear.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : restart counting (pulsed when a frame is launched)
//   post_img_href  : href returned by the sharpen pipeline
//   done           : NUM_LINES returned lines seen since the last clear
module sharpen_drain_mon
  import sharpen_pkg::*;
#(
  parameter logic [CNT_W-1:0] NUM_LINES = DEF_IMG_VDISP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic post_img_href,
  output logic done
);

  logic             href_d;
  logic [CNT_W-1:0] line_cnt;
  logic             href_fall;

  assign href_fall = href_d & ~post_img_href;
  assign done      = (line_cnt == NUM_LINES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d   <= 1'b0;
      line_cnt <= '0;
    end else begin
      // The edge detector keeps tracking through a clear so that a line
      // ending right at the clear is not seen twice.
      href_d <= post_img_href;
      if (clear)
        line_cnt <= '0;
      else if (href_fall && !done)
        line_cnt <= line_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/sharpen_frame_sched.sv
// Frame scheduler feeding a sharpen pipeline from a gray pixel stream.
// Generates per_img_vsync/href timing for one frame (or back-to-back frames
// in continuous mode), gates the upstream stream into the pipeline, and waits
// for all lines to return before reporting frame_done.
//
// Ports
//   clk, rst_n                    : clock, asynchronous active-low reset
//   start, cont_mode, stop        : frame control (start accepted only when idle)
//   s_valid, s_data, s_ready      : upstream 8-bit gray pixel stream
//   per_img_vsync/href/gray       : sharpen pipeline input timing and data
//   post_img_vsync/href           : timing returned by the sharpen pipeline
//   busy, frame_done, err_underflow : status (frame_done one-clock pulse,
//                                     err_underflow sticky)
//   frame_cnt                     : completed-frame counter, present only
//                                   when SHARPEN_SCHED_FRAME_CNT_EN is defined
//   dbg_state                     : current FSM state
//
// Handshake: a pixel moves when s_valid & s_ready. s_ready is high for exactly
// the LINE clocks and does not depend on s_valid; the line never stalls, so a
// LINE clock without s_valid emits gray 0 and flags err_underflow.
module sharpen_frame_sched
  import sharpen_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_HDISP = DEF_IMG_HDISP,
  parameter logic [CNT_W-1:0] IMG_VDISP = DEF_IMG_VDISP,
  parameter logic [7:0]       VS_LEAD   = DEF_VS_LEAD,
  parameter logic [7:0]       H_BLANK   = DEF_H_BLANK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont_mode,
  input  logic       stop,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       per_img_vsync,
  output logic       per_img_href,
  output logic [7:0] per_img_gray,
  input  logic       post_img_vsync,
  input  logic       post_img_href,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underflow,
`ifdef SHARPEN_SCHED_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output state_t     dbg_state
);

  localparam logic [CNT_W-1:0] VLEAD_LAST  = CNT_W'(VS_LEAD) - CNT_ONE;
  localparam logic [CNT_W-1:0] LINE_LAST   = IMG_HDISP - CNT_ONE;
  localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(H_BLANK) - CNT_ONE;

  state_t           state;
  logic [CNT_W-1:0] cnt;         // clocks spent in the current timed state
  logic [CNT_W-1:0] lines_sent;
  logic             stop_pend;
  logic             cont_q;
  logic             drain_done;
  logic             start_ok;
  logic             drain_exit;
  logic             restart;
  logic             in_line;

  assign in_line    = (state == ST_LINE);
  assign start_ok   = (state == ST_IDLE) && start;
  assign drain_exit = (state == ST_DRAIN) && drain_done && !post_img_vsync;
  // A stop arriving on the exit clock itself still prevents the restart.
  assign restart    = cont_q && cont_mode && !(stop_pend || stop);

  assign s_ready       = in_line;
  assign per_img_href  = in_line;
  assign per_img_gray  = (in_line && s_valid) ? s_data : 8'd0;
  // vsync falls at the start of the final blanking so the pipeline sees the
  // frame end as early as possible.
  assign per_img_vsync = (state == ST_VLEAD) || in_line ||
                         ((state == ST_HBLANK) && (lines_sent != IMG_VDISP));
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  // Returned-line counting spans the whole frame: with a short pipeline the
  // first lines come back long before DRAIN is reached.
  sharpen_drain_mon #(
    .NUM_LINES (IMG_VDISP)
  ) u_drain_mon (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (start_ok || (drain_exit && restart)),
    .post_img_href (post_img_href),
    .done          (drain_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lines_sent    <= '0;
      stop_pend     <= 1'b0;
      cont_q        <= 1'b0;
      err_underflow <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= drain_exit;
      if (stop && (state != ST_IDLE))
        stop_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_VLEAD;
            cnt           <= '0;
            lines_sent    <= '0;
            err_underflow <= 1'b0;
            cont_q        <= cont_mode;
            // start and stop together: run this frame but do not repeat it
            stop_pend     <= stop;
          end
        end
        ST_VLEAD: begin
          if (cnt == VLEAD_LAST) begin
            state <= ST_LINE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_LINE: begin
          if (!s_valid)
            err_underflow <= 1'b1;
          if (cnt == LINE_LAST) begin
            state      <= ST_HBLANK;
            cnt        <= '0;
            lines_sent <= lines_sent + CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HBLANK: begin
          if (cnt == HBLANK_LAST) begin
            cnt   <= '0;
            state <= (lines_sent < IMG_VDISP) ? ST_LINE : ST_DRAIN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (drain_exit) begin
            if (restart) begin
              state      <= ST_VLEAD;
              cnt        <= '0;
              lines_sent <= '0;
              cont_q     <= cont_mode;
            end else begin
              state     <= ST_IDLE;
              stop_pend <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHARPEN_SCHED_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= 16'd0;
    else if (drain_exit)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
